stream_source: RTL

//  Transmit end of the single-beat valid/data stream. Drives the din_valid/din inputs of

---
 rtl/stream_src_pkg.sv | 27 ++
 rtl/stream_src_if.sv | 49 ++++
 rtl/stream_src_lfsr.sv | 37 +++
 rtl/stream_source.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/stream_src_pkg.sv
// -----------------------------------------------------------------------------
// stream_src_pkg
// Shared types and constants for the stream_source traffic generator.
//   - stream_src_state_t : burst FSM states
//   - WIDTH/CNT_W/GAP_W  : default data, beat-counter and gap-counter widths
//   - LFSR_TAPS_*        : default Galois (right-shift) feedback masks
// Optional feature macro: STREAM_SRC_LFSR_EN (LFSR data pattern).
// -----------------------------------------------------------------------------
package stream_src_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } stream_src_state_t;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 16;
    localparam int GAP_W_DEF = 8;

    // Maximal-length masks for a right-shifting Galois LFSR.
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

endpackage

// File: rtl/stream_src_if.sv
// -----------------------------------------------------------------------------
// stream_src_if
// Control and beat-stream bundle of stream_source.
//   master modport (the source): takes start/abort/num_beats/gap_cycles/seed
//     (and lfsr_mode with STREAM_SRC_LFSR_EN), drives busy/done/dout_valid/dout.
//   slave modport (controller + consumer): the mirror image.
// Optional feature macro: STREAM_SRC_LFSR_EN adds lfsr_mode.
// -----------------------------------------------------------------------------
interface stream_src_if
    import stream_src_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_beats;
    logic [GAP_W-1:0] gap_cycles;
    logic [WIDTH-1:0] seed;
`ifdef STREAM_SRC_LFSR_EN
    logic             lfsr_mode;
`endif
    logic             busy;
    logic             done;
    logic             dout_valid;
    logic [WIDTH-1:0] dout;

`ifdef STREAM_SRC_LFSR_EN
    modport master (
        input  start, abort, num_beats, gap_cycles, seed, lfsr_mode,
        output busy, done, dout_valid, dout
    );
    modport slave (
        output start, abort, num_beats, gap_cycles, seed, lfsr_mode,
        input  busy, done, dout_valid, dout
    );
`else
    modport master (
        input  start, abort, num_beats, gap_cycles, seed,
        output busy, done, dout_valid, dout
    );
    modport slave (
        output start, abort, num_beats, gap_cycles, seed,
        input  busy, done, dout_valid, dout
    );
`endif

endinterface

// File: rtl/stream_src_lfsr.sv
// -----------------------------------------------------------------------------
// stream_src_lfsr
// Combinational next-word function for stream_source.
//   i_word      : current beat data
//   i_lfsr_mode : 1 = Galois LFSR step, 0 = increment (STREAM_SRC_LFSR_EN only)
//   o_next      : next beat data
// Optional feature macro: STREAM_SRC_LFSR_EN. Without it the word simply
// increments, wrapping from all-ones to zero.
// -----------------------------------------------------------------------------
module stream_src_lfsr #(
    parameter int WIDTH = 8
`ifdef STREAM_SRC_LFSR_EN
    ,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8
`endif
) (
    input  logic [WIDTH-1:0] i_word,
`ifdef STREAM_SRC_LFSR_EN
    input  logic             i_lfsr_mode,
`endif
    output logic [WIDTH-1:0] o_next
);

    logic [WIDTH-1:0] w_incr;
    assign w_incr = i_word + WIDTH'(1);

`ifdef STREAM_SRC_LFSR_EN
    // Right-shifting Galois step: the bit shifted out decides whether the
    // feedback mask is folded back in.
    logic [WIDTH-1:0] w_lfsr;
    assign w_lfsr = (i_word >> 1) ^ (i_word[0] ? LFSR_TAPS : '0);
    assign o_next = i_lfsr_mode ? w_lfsr : w_incr;
`else
    assign o_next = w_incr;
`endif

endmodule

// File: rtl/stream_source.sv
// -----------------------------------------------------------------------------
// stream_source
// Transmit end of a single-beat valid/data stream (no backpressure). Sends a
// burst of num_beats words with gap_cycles idle cycles between beats and
// pulses done for one cycle at the end.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : stream_src_if.master (start, abort, num_beats, gap_cycles, seed,
//           [lfsr_mode] in; busy, done, dout_valid, dout out)
// Optional feature macro: STREAM_SRC_LFSR_EN adds the LFSR data pattern and
// the LFSR_TAPS parameter.
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module stream_source
    import stream_src_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
`ifdef STREAM_SRC_LFSR_EN
    ,
    parameter logic [WIDTH-1:0] LFSR_TAPS = LFSR_TAPS_8
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    stream_src_if.master bus
);

    stream_src_state_t r_state;
    logic [CNT_W-1:0]  r_num_beats;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [GAP_W-1:0]  r_gap;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [WIDTH-1:0]  r_dout;
    logic              r_dout_valid;
    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  w_next;
    logic [WIDTH-1:0]  w_seed;
    logic              w_last;

`ifdef STREAM_SRC_LFSR_EN
    logic r_lfsr_mode;
    // An all-zero LFSR state never leaves zero, so substitute 1.
    assign w_seed = (bus.lfsr_mode && bus.seed == '0) ? WIDTH'(1) : bus.seed;

    stream_src_lfsr #(.WIDTH(WIDTH), .LFSR_TAPS(LFSR_TAPS)) u_next (
        .i_word      (r_dout),
        .i_lfsr_mode (r_lfsr_mode),
        .o_next      (w_next)
    );
`else
    assign w_seed = bus.seed;

    stream_src_lfsr #(.WIDTH(WIDTH)) u_next (
        .i_word (r_dout),
        .o_next (w_next)
    );
`endif

    // num_beats is never 0 in RUN, so the subtraction cannot underflow there.
    assign w_last = (r_beat_cnt == r_num_beats - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_num_beats  <= '0;
            r_beat_cnt   <= '0;
            r_gap        <= '0;
            r_gap_cnt    <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef STREAM_SRC_LFSR_EN
            r_lfsr_mode  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (bus.abort) begin
                // Abort from any busy state; in IDLE it also drops a start.
                r_state      <= IDLE;
                r_dout_valid <= 1'b0;
                r_busy       <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start) begin
                            r_num_beats <= bus.num_beats;
                            r_gap       <= bus.gap_cycles;
                            r_beat_cnt  <= '0;
                            r_busy      <= 1'b1;
`ifdef STREAM_SRC_LFSR_EN
                            r_lfsr_mode <= bus.lfsr_mode;
`endif
                            if (bus.num_beats == '0) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state      <= RUN;
                                r_dout_valid <= 1'b1;
                                r_dout       <= w_seed;
                            end
                        end
                    end
                    RUN: begin
                        if (w_last) begin
                            r_state      <= DONE;
                            r_dout_valid <= 1'b0;
                            r_done       <= 1'b1;
                        end else if (r_gap == '0) begin
                            r_dout     <= w_next;
                            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        end else begin
                            r_state      <= GAP;
                            r_dout_valid <= 1'b0;
                            r_gap_cnt    <= r_gap;
                        end
                    end
                    GAP: begin
                        // gap_cnt counts the idle cycles still to come,
                        // including the current one.
                        if (r_gap_cnt == GAP_W'(1)) begin
                            r_state      <= RUN;
                            r_dout_valid <= 1'b1;
                            r_dout       <= w_next;
                            r_beat_cnt   <= r_beat_cnt + CNT_W'(1);
                            r_gap_cnt    <= '0;
                        end else begin
                            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state      <= IDLE;
                        r_dout_valid <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.dout_valid = r_dout_valid;
    assign bus.dout       = r_dout;

endmodule
